// File: rtl/hazard_scoreboard.sv
// Load-use / long-latency scoreboard hazard unit with timed mispredict flush and registered redirect.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5,
  parameter int FLUSH_CYCLES = 2,
  localparam int NUM_REGS    = 2 ** REG_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_ID_WIDTH-1:0] reg1_id,
  input  logic [REG_ID_WIDTH-1:0] reg2_id,
  input  logic                    use_rs1_id,
  input  logic                    use_rs2_id,
  input  logic                    ex_valid,
  input  logic                    mem_read_ex,
  input  logic [REG_ID_WIDTH-1:0] rd_ex,
  input  logic                    branch_dec_ex,
  input  logic [DATA_WIDTH-1:0]   target_ex,
  input  logic [DATA_WIDTH-1:0]   pc_id,
  input  logic                    issue_valid,
  input  logic                    issue_long,
  input  logic [REG_ID_WIDTH-1:0] issue_rd,
  input  logic                    wb_valid,
  input  logic [REG_ID_WIDTH-1:0] wb_rd,
  output logic                    stall,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic [NUM_REGS-1:0]     busy_regs
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_events
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [REG_ID_WIDTH-1:0] REG_ZERO = {REG_ID_WIDTH{1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  flush_q, flush_d;
  logic                  redir_v_q, redir_v_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;

  logic [NUM_REGS-1:0]   wb_clr_s, set_mask_s, eff_busy_s;
  logic                  idle_s, load_use_s, sb_hit_s, mispredict_s, sb_set_s, stall_s;

  // Hazard detection; a same-cycle writeback forwards its data so it does not stall.
  always_comb begin
    idle_s       = (state_q == ST_IDLE);
    mispredict_s = idle_s && ex_valid && branch_dec_ex && (!id_valid || (target_ex != pc_id));
    sb_set_s     = idle_s && !mispredict_s && issue_valid && issue_long && (issue_rd != REG_ZERO);
    wb_clr_s     = {NUM_REGS{1'b0}};
    set_mask_s   = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_clr_s[r]   = wb_valid && (wb_rd == REG_ID_WIDTH'(r));
      set_mask_s[r] = sb_set_s && (issue_rd == REG_ID_WIDTH'(r));
    end
    eff_busy_s = busy_q & ~wb_clr_s;
    load_use_s = ex_valid && mem_read_ex && (rd_ex != REG_ZERO) &&
                 ((use_rs1_id && (rd_ex == reg1_id)) || (use_rs2_id && (rd_ex == reg2_id)));
    sb_hit_s   = (use_rs1_id && eff_busy_s[reg1_id]) || (use_rs2_id && eff_busy_s[reg2_id]);
    stall_s    = rst_n && id_valid && idle_s && !mispredict_s && (load_use_s || sb_hit_s);
  end

  // Next-state for flush FSM, redirect and scoreboard (set beats clear on collision).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = 1'b0;
    redir_v_d  = 1'b0;
    redir_pc_d = redir_pc_q;
    busy_d     = (busy_q & ~wb_clr_s) | set_mask_s;
    busy_d[0]  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mispredict_s) begin
          state_d    = ST_FLUSH;
          cnt_d      = CNT_INIT;
          flush_d    = 1'b1;
          redir_v_d  = 1'b1;
          redir_pc_d = target_ex;
        end else begin
          cnt_d = {CNT_W{1'b0}};
        end
      end
      ST_FLUSH: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      busy_q     <= {NUM_REGS{1'b0}};
      flush_q    <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      flush_q    <= flush_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign stall          = stall_s;
  assign flush          = flush_q;
  assign redirect_valid = redir_v_q;
  assign redirect_pc    = redir_pc_q;
  assign busy_regs      = busy_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_ev_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_ev_q  <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (mispredict_s && (flush_ev_q != 32'hFFFF_FFFF)) begin
        flush_ev_q <= flush_ev_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_ev_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized self-checking bench for hazard_scoreboard against a behavioural model, plus directed cases.
module tb_hazard_scoreboard;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int FC = 2;
  localparam int NR = 2 ** RW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, use_rs1_id, use_rs2_id, ex_valid, mem_read_ex, branch_dec_ex;
  logic [RW-1:0] reg1_id, reg2_id, rd_ex, issue_rd, wb_rd;
  logic [DW-1:0] target_ex, pc_id;
  logic          issue_valid, issue_long, wb_valid;
  logic          stall, flush, redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic [NR-1:0] busy_regs;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .reg1_id(reg1_id), .reg2_id(reg2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .ex_valid(ex_valid),
    .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .branch_dec_ex(branch_dec_ex),
    .target_ex(target_ex), .pc_id(pc_id), .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy_regs(busy_regs)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: busy set, remaining flush cycles, pending redirect.
  bit            busy_m [NR];
  int            flush_left = 0;
  bit            rv_m = 1'b0;
  logic [DW-1:0] rpc_m = 64'd0;
  bit            model_ok = 1'b0;
  longint        stall_cnt_m = 0;
  longint        flush_ev_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mispredict();
    return (flush_left == 0) && ex_valid && branch_dec_ex && (!id_valid || (target_ex != pc_id));
  endfunction

  function automatic bit m_stall();
    bit lu, r1_busy, r2_busy;
    lu = ex_valid && mem_read_ex && (rd_ex != 5'd0) &&
         ((use_rs1_id && rd_ex == reg1_id) || (use_rs2_id && rd_ex == reg2_id));
    r1_busy = busy_m[reg1_id] && !(wb_valid && wb_rd == reg1_id);
    r2_busy = busy_m[reg2_id] && !(wb_valid && wb_rd == reg2_id);
    return rst_n && id_valid && (flush_left == 0) && !m_mispredict() &&
           (lu || (use_rs1_id && r1_busy) || (use_rs2_id && r2_busy));
  endfunction

  always @(posedge clk) begin : model_update
    bit mp, st;
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) busy_m[r] = 1'b0;
      flush_left = 0; rv_m = 1'b0; rpc_m = 64'd0;
      stall_cnt_m = 0; flush_ev_m = 0;
      model_ok = 1'b1;
    end else begin
      mp = m_mispredict();
      st = m_stall();
      if (st && stall_cnt_m < 64'hFFFF_FFFF) stall_cnt_m++;
      if (mp && flush_ev_m < 64'hFFFF_FFFF) flush_ev_m++;
      if (wb_valid) busy_m[wb_rd] = 1'b0;
      if (!mp && flush_left == 0 && issue_valid && issue_long && issue_rd != 5'd0)
        busy_m[issue_rd] = 1'b1;
      if (mp) begin
        flush_left = FC; rv_m = 1'b1; rpc_m = target_ex;
      end else begin
        if (flush_left > 0) flush_left--;
        rv_m = 1'b0;
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [NR-1:0] exp_busy;
    if (model_ok) begin
      for (int r = 0; r < NR; r++) exp_busy[r] = busy_m[r];
      chk("stall", {63'd0, stall}, {63'd0, m_stall()});
      chk("flush", {63'd0, flush}, {63'd0, flush_left > 0});
      chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, rv_m});
      chk("redirect_pc", redirect_pc, rpc_m);
      chk("busy_regs", {32'd0, busy_regs}, {32'd0, exp_busy});
`ifdef HAZARD_STATS_EN
      chk("stall_cycles", {32'd0, stall_cycles}, stall_cnt_m);
      chk("flush_events", {32'd0, flush_events}, flush_ev_m);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; reg1_id = 5'd0; reg2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    ex_valid = 1'b0; mem_read_ex = 1'b0; rd_ex = 5'd0; branch_dec_ex = 1'b0;
    target_ex = 64'd0; pc_id = 64'd0; issue_valid = 1'b0; issue_long = 1'b0;
    issue_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    // Reset state; load-use present but stall forced low.
    ex_valid = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd5; reg1_id = 5'd5; use_rs1_id = 1'b1; id_valid = 1'b1;
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_busy", {32'd0, busy_regs}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_rv", {63'd0, redirect_valid}, 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("load_use", {63'd0, stall}, 64'd1);
    rd_ex = 5'd0; reg1_id = 5'd0;
    #1 chk("load_use_x0", {63'd0, stall}, 64'd0);
    idle_inputs();
    // Scoreboard set, stall, writeback forward and clear.
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs(); id_valid = 1'b1; reg1_id = 5'd7; use_rs1_id = 1'b1;
    #1 chk("sb_stall_t1", {63'd0, stall}, 64'd1);
    chk("sb_busy7_t1", {63'd0, busy_regs[7]}, 64'd1);
    tick();
    #1 chk("sb_stall_t2", {63'd0, stall}, 64'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1 chk("sb_wb_fwd", {63'd0, stall}, 64'd0);
    chk("sb_busy7_t3", {63'd0, busy_regs[7]}, 64'd1);
    tick();
    wb_valid = 1'b0;
    #1 chk("sb_busy7_t4", {63'd0, busy_regs[7]}, 64'd0);
    chk("sb_stall_t4", {63'd0, stall}, 64'd0);
    // Set/clear collision: set wins.
    idle_inputs();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    idle_inputs();
    #1 chk("collision_busy9", {63'd0, busy_regs[9]}, 64'd1);
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    idle_inputs();
    // Mispredict with wrong-path branch during flush.
    ex_valid = 1'b1; branch_dec_ex = 1'b1; target_ex = 64'h1000; pc_id = 64'h2000; id_valid = 1'b1;
    tick();
    target_ex = 64'h3000;
    #1 chk("mp_rv_t1", {63'd0, redirect_valid}, 64'd1);
    chk("mp_rpc_t1", redirect_pc, 64'h1000);
    chk("mp_flush_t1", {63'd0, flush}, 64'd1);
    tick();
    #1 chk("mp_flush_t2", {63'd0, flush}, 64'd1);
    chk("mp_rv_t2", {63'd0, redirect_valid}, 64'd0);
    tick();
    ex_valid = 1'b0; branch_dec_ex = 1'b0;
    #1 chk("mp_flush_t3", {63'd0, flush}, 64'd0);
    chk("mp_rpc_hold", redirect_pc, 64'h1000);
    // Correct prediction: no flush.
    ex_valid = 1'b1; branch_dec_ex = 1'b1; target_ex = 64'h2000; pc_id = 64'h2000;
    tick();
    idle_inputs();
    #1 chk("match_flush", {63'd0, flush}, 64'd0);
    chk("match_rv", {63'd0, redirect_valid}, 64'd0);
    // Reset in the middle of a flush sequence.
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
    tick();
    idle_inputs();
    ex_valid = 1'b1; branch_dec_ex = 1'b1; target_ex = 64'h4000; pc_id = 64'h2000; id_valid = 1'b1;
    tick();
    idle_inputs(); rst_n = 1'b0;
    #1 chk("rmf_flush_before", {63'd0, flush}, 64'd1);
    tick();
    rst_n = 1'b1;
    #1 chk("rmf_flush", {63'd0, flush}, 64'd0);
    chk("rmf_rv", {63'd0, redirect_valid}, 64'd0);
    chk("rmf_rpc", redirect_pc, 64'd0);
    chk("rmf_busy", {32'd0, busy_regs}, 64'd0);
`ifdef HAZARD_STATS_EN
    chk("stats_rst_stall", {32'd0, stall_cycles}, 64'd0);
    chk("stats_rst_flush", {32'd0, flush_events}, 64'd0);
    ex_valid = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd4; reg1_id = 5'd4; use_rs1_id = 1'b1; id_valid = 1'b1;
    tick(); tick(); tick();
    idle_inputs();
    ex_valid = 1'b1; branch_dec_ex = 1'b1; target_ex = 64'h80; pc_id = 64'h90; id_valid = 1'b1;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    chk("stats_stall_3", {32'd0, stall_cycles}, 64'd3);
    chk("stats_flush_1", {32'd0, flush_events}, 64'd1);
`endif
    // Randomized phase, regs confined to x0..x7 to provoke hazards.
    for (int c = 0; c < 2000; c++) begin
      rst_n         = ($urandom_range(0, 149) != 0);
      id_valid      = 1'($urandom_range(0, 3) != 0);
      reg1_id       = RW'($urandom_range(0, 7));
      reg2_id       = RW'($urandom_range(0, 7));
      use_rs1_id    = 1'($urandom_range(0, 1));
      use_rs2_id    = 1'($urandom_range(0, 1));
      ex_valid      = 1'($urandom_range(0, 3) != 0);
      mem_read_ex   = ($urandom_range(0, 2) == 0);
      rd_ex         = RW'($urandom_range(0, 7));
      branch_dec_ex = ($urandom_range(0, 9) == 0);
      pc_id         = {32'd0, 20'd0, 12'($urandom_range(0, 3)) << 8};
      target_ex     = ($urandom_range(0, 1) == 0) ? pc_id : {32'd0, $urandom};
      issue_valid   = 1'($urandom_range(0, 1));
      issue_long    = 1'($urandom_range(0, 1));
      issue_rd      = RW'($urandom_range(0, 7));
      wb_valid      = ($urandom_range(0, 2) == 0);
      wb_rd         = RW'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
